// File: rtl/sao_deci_pkg.sv
// Shared types and constants for the SAO decision sequencer.
package sao_deci_pkg;

  localparam int unsigned EO_WIN = 4;
  localparam int unsigned NUM_EO = 4;

  typedef enum logic [2:0] {
    SaoOff = 3'd0,
    SaoEo0 = 3'd1,
    SaoEo1 = 3'd2,
    SaoEo2 = 3'd3,
    SaoEo3 = 3'd4,
    SaoBo  = 3'd5
  } sao_type_e;

  typedef enum logic [2:0] {
    StIdle,
    StClr,
    StRun,
    StDrain,
    StDecide,
    StOut
  } state_e;

endpackage

// File: rtl/sao_deci_min5.sv
// Signed 5-way minimum over EO0..EO3 and BO, lower index wins ties, non-negative -> OFF.
module sao_deci_min5
  import sao_deci_pkg::*;
#(
  parameter int unsigned DIST_W = 25
) (
  input  logic [DIST_W-1:0] eo0,
  input  logic [DIST_W-1:0] eo1,
  input  logic [DIST_W-1:0] eo2,
  input  logic [DIST_W-1:0] eo3,
  input  logic [DIST_W-1:0] bo,
  output logic [2:0]        idx,
  output logic [DIST_W-1:0] value
);

  logic signed [DIST_W-1:0] best;
  sao_type_e                sel;

  always_comb begin
    best = $signed(eo0);
    sel  = SaoEo0;
    // Strict less-than keeps the earlier candidate on a tie.
    if ($signed(eo1) < best) begin best = $signed(eo1); sel = SaoEo1; end
    if ($signed(eo2) < best) begin best = $signed(eo2); sel = SaoEo2; end
    if ($signed(eo3) < best) begin best = $signed(eo3); sel = SaoEo3; end
    if ($signed(bo)  < best) begin best = $signed(bo);  sel = SaoBo;  end

    if (!best[DIST_W-1]) begin
      idx   = SaoOff;
      value = '0;
    end else begin
      idx   = sel;
      value = best;
    end
  end

endmodule

// File: rtl/sao_deci_seq_ctrl.sv
// Per-CTB sequencer: clears, steps and captures the distortion accumulator per component,
// then picks OFF/EO/BO and hands each result downstream over valid/ready.
module sao_deci_seq_ctrl
  import sao_deci_pkg::*;
#(
  parameter int unsigned DIST_W   = 25,
  parameter int unsigned CNT_LAST = 24,
  parameter int unsigned NUM_COMP = 3
) (
  input  logic              clk,
  input  logic              arst_n,
  input  logic              start,
  input  logic              left_merge_avail,
  input  logic              upper_merge_avail,
  input  logic              dist_valid,
  output logic              dist_ready,
  output logic              accu_en,
  output logic              accu_rst_n,
  output logic [5:0]        accu_cnt,
  input  logic [5:0]        accu_cnt_r1,
  input  logic [DIST_W-1:0] dist_one_type,
  input  logic [DIST_W-1:0] dist_bo_type_best,
  input  logic [2:0]        best_bo_category,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [1:0]        res_cidx,
  output logic [2:0]        res_type,
  output logic [2:0]        res_band,
  output logic [DIST_W-1:0] res_cost,
  output logic              res_merge_left,
  output logic              res_merge_up,
  output logic              busy,
  output logic              done
);

  state_e            state_q, state_d;
  logic [1:0]        cidx_q;
  logic [5:0]        cnt_q;
  logic              en_d1_q;
  logic [DIST_W-1:0] eo_cost_q [NUM_EO];
  logic [DIST_W-1:0] bo_cost_q;
  logic [2:0]        bo_band_q;
  logic              merge_left_q, merge_up_q, done_q;
  logic [2:0]        res_type_q, res_band_q;
  logic [DIST_W-1:0] res_cost_q;
  logic [2:0]        min_idx;
  logic [DIST_W-1:0] min_value;
  logic              cnt_last, last_comp, accept, start_ok;

  assign cnt_last  = (cnt_q == 6'(CNT_LAST));
  assign last_comp = (cidx_q == 2'(NUM_COMP - 1));
  assign accept    = res_valid & res_ready;
  // A start landing on the done cycle is dropped.
  assign start_ok  = start & ~done_q;

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) state_q <= StIdle;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:   if (start_ok) state_d = StClr;
      StClr:    state_d = StRun;
      StRun:    if (accu_en && cnt_last) state_d = StDrain;
      StDrain:  state_d = StDecide;
      StDecide: state_d = StOut;
      StOut:    if (accept) state_d = last_comp ? StIdle : StClr;
      default:  state_d = StIdle;
    endcase
  end

  always_comb begin
    dist_ready = (state_q == StRun);
    accu_en    = dist_valid & dist_ready;
    accu_rst_n = (state_q != StClr);
    accu_cnt   = cnt_q;
    res_valid  = (state_q == StOut);
    busy       = (state_q != StIdle);
    done       = done_q;
  end

  sao_deci_min5 #(
    .DIST_W (DIST_W)
  ) u_min5 (
    .eo0   (eo_cost_q[0]),
    .eo1   (eo_cost_q[1]),
    .eo2   (eo_cost_q[2]),
    .eo3   (eo_cost_q[3]),
    .bo    (bo_cost_q),
    .idx   (min_idx),
    .value (min_value)
  );

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      cidx_q       <= '0;
      cnt_q        <= '0;
      en_d1_q      <= 1'b0;
      for (int k = 0; k < NUM_EO; k++) eo_cost_q[k] <= '0;
      bo_cost_q    <= '0;
      bo_band_q    <= '0;
      merge_left_q <= 1'b0;
      merge_up_q   <= 1'b0;
      done_q       <= 1'b0;
      res_type_q   <= '0;
      res_band_q   <= '0;
      res_cost_q   <= '0;
    end else begin
      en_d1_q <= accu_en;
      done_q  <= (state_q == StOut) && accept && last_comp;

      if (state_q == StIdle && start_ok) begin
        cidx_q       <= '0;
        merge_left_q <= left_merge_avail;
        merge_up_q   <= upper_merge_avail;
      end else if (state_q == StOut && accept && !last_comp) begin
        cidx_q <= cidx_q + 2'd1;
      end

      if (state_q == StClr)           cnt_q <= '0;
      else if (accu_en && !cnt_last)  cnt_q <= cnt_q + 6'd1;

      // accu_cnt_r1 holds across stalls, so only the cycle after a real enable may capture.
      if (state_q == StClr) begin
        for (int k = 0; k < NUM_EO; k++) eo_cost_q[k] <= '0;
        bo_cost_q <= '0;
        bo_band_q <= '0;
      end else if (en_d1_q) begin
        for (int k = 0; k < NUM_EO; k++) begin
          if (accu_cnt_r1 == 6'(EO_WIN * (k + 1))) eo_cost_q[k] <= dist_one_type;
        end
        if (accu_cnt_r1 == 6'(CNT_LAST)) begin
          bo_cost_q <= dist_bo_type_best;
          bo_band_q <= best_bo_category;
        end
      end

      if (state_q == StDecide) begin
        res_type_q <= min_idx;
        res_cost_q <= min_value;
        res_band_q <= (min_idx == SaoBo) ? bo_band_q : 3'd0;
      end
    end
  end

  assign res_cidx       = cidx_q;
  assign res_type       = res_type_q;
  assign res_band       = res_band_q;
  assign res_cost       = res_cost_q;
  assign res_merge_left = merge_left_q;
  assign res_merge_up   = merge_up_q;

endmodule
